lsu_mem_master: RTL and testbench

//  CPU-side initiator for the byte-addressed unified memory (memRead/memWrite/address/writeData/memData).

---
 rtl/rv32_mem_pkg.sv | 34 +++
 rtl/lsu_lane_align.sv | 61 ++++++
 rtl/lsu_mem_master.sv | 119 +++++++++++
 tb/tb_lsu_mem_master.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared RV32 load/store encodings, LSU state encoding and memory size default.
// Used by lsu_mem_master and lsu_lane_align.
package rv32_mem_pkg;

    localparam int MEM_BYTES_DEFAULT = 1024;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_MERGE = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        LSU_IDLE  = ST_IDLE,
        LSU_READ  = ST_READ,
        LSU_MERGE = ST_MERGE,
        LSU_WRITE = ST_WRITE,
        LSU_DONE  = ST_DONE
    } lsu_state_e;

    function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
        if (write)
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: sub-word load extract/extend and store merge.
// Halfwords use lane[1] only; words ignore the lane.
module lsu_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        sel_byte = word[7:0];
        case (lane)
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            2'd3:    sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase
        sel_half = lane[1] ? word[31:16] : word[15:0];

        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merge_data = wdata;
        case (funct3)
            F3_B: begin
                merge_data = word;
                case (lane)
                    2'd1:    merge_data[15:8]  = wdata[7:0];
                    2'd2:    merge_data[23:16] = wdata[7:0];
                    2'd3:    merge_data[31:24] = wdata[7:0];
                    default: merge_data[7:0]   = wdata[7:0];
                endcase
            end
            F3_H: begin
                merge_data = word;
                if (lane[1])
                    merge_data[31:16] = wdata[15:0];
                else
                    merge_data[15:0] = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit master for the word-wide unified memory; SB/SH done as read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error responses.
module lsu_mem_master
    import rv32_mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] address,
    output logic [31:0] writeData,
    input  logic [31:0] memData
);

    lsu_state_e  state;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;

    logic        hs;
    logic        req_err;
    logic        range_err;
    logic        misalign_err;
    logic [32:0] range_end;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign range_end = {1'b0, req_addr[31:2], 2'b00} + 33'd3;
    assign range_err = range_end >= 33'(MEM_BYTES);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misalign_err = 1'b0;
        if (req_funct3 == F3_H || req_funct3 == F3_HU)
            misalign_err = req_addr[0];
        else if (req_funct3 == F3_W)
            misalign_err = req_addr[1:0] != 2'b00;
    end
`else
    assign misalign_err = 1'b0;
`endif

    assign req_err   = !f3_legal(req_write, req_funct3) || range_err || misalign_err;
    assign req_ready = !reset && (state == LSU_IDLE);
    assign hs        = req_valid && req_ready;

    lsu_lane_align u_align (
        .funct3     (r_funct3),
        .lane       (r_addr[1:0]),
        .word       (memData),
        .wdata      (r_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LSU_IDLE;
            r_write  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (hs) begin
                        r_write  <= req_write;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_err    <= req_err;
                        if (req_err)
                            state <= LSU_DONE;
                        else if (req_write && req_funct3 == F3_W)
                            state <= LSU_WRITE;
                        else
                            state <= LSU_READ;
                    end
                end
                LSU_READ:  state <= r_write ? LSU_MERGE : LSU_DONE;
                LSU_MERGE: begin
                    // memData now holds the old word; fold the store lanes into it.
                    r_wdata <= merge_data;
                    state   <= LSU_WRITE;
                end
                LSU_WRITE: state <= LSU_DONE;
                LSU_DONE:  state <= LSU_IDLE;
                default:   state <= LSU_IDLE;
            endcase
        end
    end

    // Strobes are gated by reset so a WRITE cycle that coincides with reset never reaches memory.
    assign memRead    = !reset && (state == LSU_READ);
    assign memWrite   = !reset && (state == LSU_WRITE);
    assign address    = reset ? 32'h0 : {r_addr[31:2], 2'b00};
    assign writeData  = reset ? 32'h0 : r_wdata;

    assign resp_valid = !reset && (state == LSU_DONE);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = (resp_valid && !r_write && !r_err) ? load_data : 32'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a registered-read memory model.
// Expected values follow LSU_MISALIGN_TRAP_EN if it is defined for the build.
module tb_lsu_mem_master;
    import rv32_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] memData;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lsu_mem_master dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .address    (address),
        .writeData  (writeData),
        .memData    (memData)
    );

    // Byte-addressed 1 KiB memory stored as words; read data is registered.
    logic [31:0] mem [256];
    logic        mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h00002083;
            mem[1] <= 32'h00108133;
        end else begin
            if (memWrite) mem[address[9:2]] <= writeData;
            if (memRead) memData <= mem[address[9:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
        int          exp_rd_at;
        int          exp_wr_at;
        logic [31:0] exp_maddr;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[$];

    // One request; watches strobes and the response for a bounded number of cycles.
    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output int nrd, output int nwr, output int rd_at, output int wr_at,
                           output logic [31:0] maddr, output logic [31:0] wd_seen);
        lat = -1; rdata = 32'hx; err = 1'bx;
        nrd = 0; nwr = 0; rd_at = 0; wr_at = 0; maddr = 32'h0; wd_seen = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge clk);
            if (memRead) begin nrd++; rd_at = n; maddr = address; end
            if (memWrite) begin nwr++; wr_at = n; maddr = address; wd_seen = writeData; end
            if (resp_valid) begin lat = n; rdata = resp_rdata; err = resp_err; end
        end
    endtask

    int          lat, nrd, nwr, rd_at, wr_at;
    logic [31:0] rdata, maddr, wd_seen;
    logic        err;

    initial begin
        // name, w, f3, addr, wdata, rdata, err, lat, nrd, nwr, rd_at, wr_at, maddr, wd
        vecs.push_back('{"lb_0",     1'b0, F3_B,  32'h000, 32'h0,        32'hFFFFFF83, 1'b0, 2, 1, 0, 1, 0, 32'h000, 32'h0});
        vecs.push_back('{"lbu_0",    1'b0, F3_BU, 32'h000, 32'h0,        32'h00000083, 1'b0, 2, 1, 0, 1, 0, 32'h000, 32'h0});
        vecs.push_back('{"lh_6",     1'b0, F3_H,  32'h006, 32'h0,        32'h00000010, 1'b0, 2, 1, 0, 1, 0, 32'h004, 32'h0});
        vecs.push_back('{"lw_4",     1'b0, F3_W,  32'h004, 32'h0,        32'h00108133, 1'b0, 2, 1, 0, 1, 0, 32'h004, 32'h0});
        vecs.push_back('{"sb_101",   1'b1, F3_B,  32'h101, 32'h123456AB, 32'h0,        1'b0, 4, 1, 1, 1, 3, 32'h100, 32'h0000AB00});
        vecs.push_back('{"lw_100",   1'b0, F3_W,  32'h100, 32'h0,        32'h0000AB00, 1'b0, 2, 1, 0, 1, 0, 32'h100, 32'h0});
        vecs.push_back('{"sw_3fc",   1'b1, F3_W,  32'h3FC, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 0, 1, 32'h3FC, 32'hDEADBEEF});
        vecs.push_back('{"lw_3fc",   1'b0, F3_W,  32'h3FC, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 1, 0, 32'h3FC, 32'h0});
        vecs.push_back('{"lw_400",   1'b0, F3_W,  32'h400, 32'h0,        32'h0,        1'b1, 1, 0, 0, 0, 0, 32'h0,   32'h0});
        vecs.push_back('{"lb_401",   1'b0, F3_B,  32'h401, 32'h0,        32'h0,        1'b1, 1, 0, 0, 0, 0, 32'h0,   32'h0});
        vecs.push_back('{"ld_f3_011",1'b0, 3'b011,32'h000, 32'h0,        32'h0,        1'b1, 1, 0, 0, 0, 0, 32'h0,   32'h0});
        vecs.push_back('{"st_f3_011",1'b1, 3'b011,32'h000, 32'h0,        32'h0,        1'b1, 1, 0, 0, 0, 0, 32'h0,   32'h0});
        vecs.push_back('{"st_f3_100",1'b1, 3'b100,32'h000, 32'h0,        32'h0,        1'b1, 1, 0, 0, 0, 0, 32'h0,   32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{"lw_102",   1'b0, F3_W,  32'h102, 32'h0,        32'h0,        1'b1, 1, 0, 0, 0, 0, 32'h0,   32'h0});
`else
        vecs.push_back('{"lw_102",   1'b0, F3_W,  32'h102, 32'h0,        32'h0000AB00, 1'b0, 2, 1, 0, 1, 0, 32'h100, 32'h0});
`endif
        vecs.push_back('{"sh_102",   1'b1, F3_H,  32'h102, 32'h0000CAFE, 32'h0,        1'b0, 4, 1, 1, 1, 3, 32'h100, 32'hCAFEAB00});
        vecs.push_back('{"lhu_102",  1'b0, F3_HU, 32'h102, 32'h0,        32'h0000CAFE, 1'b0, 2, 1, 0, 1, 0, 32'h100, 32'h0});
        vecs.push_back('{"lh_102",   1'b0, F3_H,  32'h102, 32'h0,        32'hFFFFCAFE, 1'b0, 2, 1, 0, 1, 0, 32'h100, 32'h0});
        vecs.push_back('{"lb_103",   1'b0, F3_B,  32'h103, 32'h0,        32'hFFFFFFCA, 1'b0, 2, 1, 0, 1, 0, 32'h100, 32'h0});
        vecs.push_back('{"lbu_101",  1'b0, F3_BU, 32'h101, 32'h0,        32'h000000AB, 1'b0, 2, 1, 0, 1, 0, 32'h100, 32'h0});
        vecs.push_back('{"sb_3ff",   1'b1, F3_B,  32'h3FF, 32'h00000011, 32'h0,        1'b0, 4, 1, 1, 1, 3, 32'h3FC, 32'h11ADBEEF});
        vecs.push_back('{"lw_3fc_2", 1'b0, F3_W,  32'h3FC, 32'h0,        32'h11ADBEEF, 1'b0, 2, 1, 0, 1, 0, 32'h3FC, 32'h0});
        vecs.push_back('{"lh_3fe",   1'b0, F3_H,  32'h3FE, 32'h0,        32'h000011AD, 1'b0, 2, 1, 0, 1, 0, 32'h3FC, 32'h0});

        // Reset state, with a request pending that must be ignored.
        reset = 1'b1; mem_clear = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_memRead", {31'h0, memRead}, 32'h0);
        check("rst_memWrite", {31'h0, memWrite}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_writeData", writeData, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        reset = 1'b0; mem_clear = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'h0, req_ready}, 32'h1);

        foreach (vecs[i]) begin
            run_txn(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    lat, rdata, err, nrd, nwr, rd_at, wr_at, maddr, wd_seen);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"}, {31'h0, err}, {31'h0, vecs[i].exp_err});
            check({vecs[i].name, "_nrd"}, 32'(nrd), 32'(vecs[i].exp_nrd));
            check({vecs[i].name, "_nwr"}, 32'(nwr), 32'(vecs[i].exp_nwr));
            check({vecs[i].name, "_rd_at"}, 32'(rd_at), 32'(vecs[i].exp_rd_at));
            check({vecs[i].name, "_wr_at"}, 32'(wr_at), 32'(vecs[i].exp_wr_at));
            if (vecs[i].exp_nrd + vecs[i].exp_nwr > 0)
                check({vecs[i].name, "_maddr"}, maddr, vecs[i].exp_maddr);
            if (vecs[i].exp_nwr > 0)
                check({vecs[i].name, "_wdata"}, wd_seen, vecs[i].exp_wd);
        end

        // req_valid held high and address changed mid-transaction: must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h4;
        @(posedge clk);
        #1 req_addr = 32'h0;
        @(negedge clk);
        check("hold_read_strobe", {31'h0, memRead}, 32'h1);
        check("hold_read_addr", address, 32'h4);
        check("hold_ready_busy", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("hold_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("hold_rdata", resp_rdata, 32'h00108133);
        req_valid = 1'b0;
        @(negedge clk);
        check("pulse_resp_valid_low", {31'h0, resp_valid}, 32'h0);
        check("pulse_rdata_zero", resp_rdata, 32'h0);
        check("pulse_memRead_low", {31'h0, memRead}, 32'h0);

        // Reset lands in the WRITE cycle of an SH: write suppressed, no response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_H; req_addr = 32'h0; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("shrst_in_write", {31'h0, memWrite}, 32'h1);
        check("shrst_merged", writeData, 32'h0000BEEF);
        reset = 1'b1;
        #1;
        check("shrst_memWrite_gated", {31'h0, memWrite}, 32'h0);
        check("shrst_no_resp", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        check("shrst_no_resp_in_rst", {31'h0, resp_valid}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("shrst_ready_after", {31'h0, req_ready}, 32'h1);
        check("shrst_no_resp_after", {31'h0, resp_valid}, 32'h0);
        check("shrst_mem_unchanged", mem[0], 32'h00002083);
        run_txn(1'b0, F3_W, 32'h0, 32'h0, lat, rdata, err, nrd, nwr, rd_at, wr_at, maddr, wd_seen);
        check("shrst_lw0_rdata", rdata, 32'h00002083);
        check("shrst_lw0_lat", 32'(lat), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
